// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the multi-port writeback stage.
//   XLEN_D / NREGS_D : default register width and register count
//   wb_state_t       : writeback run/halt state encoding
//   OPC_MULDIV       : opcode the execute stage uses when it builds
//                      two-channel (RAX+RDX) packets
package wb_pkg;

  localparam int XLEN_D  = 64;
  localparam int NREGS_D = 16;

  localparam logic [7:0] OPC_MULDIV = 8'd247;

  typedef enum logic [1:0] {
    RUN,
    PENDING_HALT,
    HALTED
  } wb_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register busy bits for decode hazard tracking.
// Ports:
//   clk      in  clock
//   reset    in  synchronous active-high reset (clears every busy bit)
//   set_mask in  registers reserved by decode this cycle
//   clr_mask in  registers written back this cycle
//   busy     out bit i = a write to register i is still pending
// A reservation belongs to a younger instruction than the retiring write,
// so when a bit is set and cleared together the set wins.
module wb_scoreboard #(
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREGS-1:0] set_mask,
  input  logic [NREGS-1:0] clr_mask,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/mod_wb_multiport.sv
// mod_wb_multiport: writeback stage owning the architectural register file.
// Commits up to NWR destination writes per accepted EX/WB packet, tracks a
// busy scoreboard for decode, serves NRD combinational read ports and halts
// on a sim-end packet once all outstanding writes have drained.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid / in_ready     packet handshake (transfer when both high)
//   in_wen, in_widx,
//   in_wdata                per-channel write enable / index / data;
//                           channel k at [k*IDXW +: IDXW] / [k*XLEN +: XLEN]
//   in_sim_end              packet is the last instruction
//   rsv_valid, rsv_mask     decode reservation of destination registers
//   rd_idx, rd_data         NRD read ports (out-of-range index reads 0)
//   busy                    scoreboard, one bit per register
//   halted                  sim-end packet retired and writes drained
//   retired_cnt             saturating accepted-packet counter
// Build option: define WB_BYPASS_EN to forward same-cycle accepted write
// data straight to the read ports (zero-cycle read-after-write).
module mod_wb_multiport
  import wb_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int NREGS = NREGS_D,
  parameter int NWR   = 2,
  parameter int NRD   = 2,
  parameter int IDXW  = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NWR-1:0]      in_wen,
  input  logic [NWR*IDXW-1:0] in_widx,
  input  logic [NWR*XLEN-1:0] in_wdata,
  input  logic                in_sim_end,
  input  logic                rsv_valid,
  input  logic [NREGS-1:0]    rsv_mask,
  input  logic [NRD*IDXW-1:0] rd_idx,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NREGS-1:0]    busy,
  output logic                halted,
  output logic [31:0]         retired_cnt
);

  wb_state_t state_q;
  wb_state_t state_d;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [31:0]      retired_q;
  logic [31:0]      retired_d;

  logic             accept;
  logic [NREGS-1:0] wr_en;
  logic [XLEN-1:0]  wr_val [NREGS];
  logic [NREGS-1:0] set_mask;

`ifdef WB_BYPASS_EN
  // Channel k carries an accepted, in-range write this cycle.
  logic [NWR-1:0]   ch_wr;
`endif

  assign accept = in_valid & in_ready;

  // Per-register write decode. Channels are scanned in ascending order so
  // the highest-numbered enabled channel overrides on a shared index.
  // Indices >= NREGS never match any register and are therefore dropped.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      wr_en[i]  = 1'b0;
      wr_val[i] = '0;
    end
`ifdef WB_BYPASS_EN
    ch_wr = '0;
`endif
    for (int k = 0; k < NWR; k++) begin
      for (int i = 0; i < NREGS; i++) begin
        if (accept && in_wen[k] && (in_widx[k*IDXW +: IDXW] == IDXW'(i))) begin
          wr_en[i]  = 1'b1;
          wr_val[i] = in_wdata[k*XLEN +: XLEN];
`ifdef WB_BYPASS_EN
          ch_wr[k]  = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reset) begin
        regs_q[i] <= '0;
      end else if (wr_en[i]) begin
        regs_q[i] <= wr_val[i];
      end
    end
  end

  assign set_mask = rsv_valid ? rsv_mask : '0;

  wb_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_mask (set_mask),
    .clr_mask (wr_en),
    .busy     (busy)
  );

  // Halt sequencing: a sim-end packet seen with writes still outstanding
  // keeps the stage running until the scoreboard drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (accept && in_sim_end) begin
          state_d = (busy != '0) ? PENDING_HALT : HALTED;
        end
      end
      PENDING_HALT: begin
        if (busy == '0) begin
          state_d = HALTED;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (accept && (retired_q != 32'hFFFF_FFFF)) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign in_ready    = (state_q != HALTED);
  assign halted      = (state_q == HALTED);
  assign retired_cnt = retired_q;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [IDXW-1:0] idx;
      logic [XLEN-1:0] rd_word;

      assign idx = rd_idx[gi*IDXW +: IDXW];

      always_comb begin
        rd_word = '0;
        for (int i = 0; i < NREGS; i++) begin
          if (idx == IDXW'(i)) begin
            rd_word = regs_q[i];
          end
        end
`ifdef WB_BYPASS_EN
        for (int k = 0; k < NWR; k++) begin
          if (ch_wr[k] && (in_widx[k*IDXW +: IDXW] == idx)) begin
            rd_word = in_wdata[k*XLEN +: XLEN];
          end
        end
`endif
      end

      assign rd_data[gi*XLEN +: XLEN] = rd_word;
    end
  endgenerate

endmodule

// File: tb/tb_mod_wb_multiport.sv
// tb_mod_wb_multiport: directed scoreboard bench for mod_wb_multiport.
// Stimulus pushes the expected observation for the current cycle into a
// queue; a monitor on the falling edge pops and compares each entry.
module tb_mod_wb_multiport;

  localparam int XLEN  = 64;
  localparam int NREGS = 16;
  localparam int NWR   = 2;
  localparam int NRD   = 2;
  localparam int IDXW  = 4;

  // Observation selectors
  localparam int K_RD0   = 0;
  localparam int K_RD1   = 1;
  localparam int K_BUSY  = 2;
  localparam int K_HALT  = 3;
  localparam int K_READY = 4;
  localparam int K_RET   = 5;

  logic                clk;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [NWR-1:0]      in_wen;
  logic [NWR*IDXW-1:0] in_widx;
  logic [NWR*XLEN-1:0] in_wdata;
  logic                in_sim_end;
  logic                rsv_valid;
  logic [NREGS-1:0]    rsv_mask;
  logic [NRD*IDXW-1:0] rd_idx;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NREGS-1:0]    busy;
  logic                halted;
  logic [31:0]         retired_cnt;

  mod_wb_multiport #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NWR   (NWR),
    .NRD   (NRD),
    .IDXW  (IDXW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wen      (in_wen),
    .in_widx     (in_widx),
    .in_wdata    (in_wdata),
    .in_sim_end  (in_sim_end),
    .rsv_valid   (rsv_valid),
    .rsv_mask    (rsv_mask),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data),
    .busy        (busy),
    .halted      (halted),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [63:0] exp;
    string       name;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] observe(input int kind);
    case (kind)
      K_RD0:   return rd_data[63:0];
      K_RD1:   return rd_data[127:64];
      K_BUSY:  return {48'd0, busy};
      K_HALT:  return {63'd0, halted};
      K_READY: return {63'd0, in_ready};
      default: return {32'd0, retired_cnt};
    endcase
  endfunction

  // Monitor: compare every expectation that belongs to the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e   = sb_q.pop_front();
      act = observe(e.kind);
      tests++;
      if (e.cyc != cyc || act !== e.exp) begin
        fails++;
        $display("FAIL %s: got %h, expected %h (cycle %0d)", e.name, act, e.exp, cyc);
      end else begin
        $display("PASS %s: %h (cycle %0d)", e.name, act, cyc);
      end
    end
  end

  task automatic expect_obs(input int kind, input logic [63:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    e.cyc  = cyc;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_wen     = '0;
    in_widx    = '0;
    in_wdata   = '0;
    in_sim_end = 1'b0;
    rsv_valid  = 1'b0;
    rsv_mask   = '0;
  endtask

  task automatic wr(input int ch, input logic [3:0] idx, input logic [63:0] d);
    in_valid               = 1'b1;
    in_wen[ch]             = 1'b1;
    in_widx[ch*IDXW +: 4]  = idx;
    in_wdata[ch*XLEN +: 64] = d;
  endtask

  task automatic expect_reset_state(input string tag);
    expect_obs(K_BUSY,  64'd0, {tag, "_busy"});
    expect_obs(K_HALT,  64'd0, {tag, "_halted"});
    expect_obs(K_READY, 64'd1, {tag, "_ready"});
    expect_obs(K_RET,   64'd0, {tag, "_retired"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset  = 1'b1;
    rd_idx = '0;
    tick();
    tick();
    reset = 1'b0;
    expect_reset_state("rst");
    expect_obs(K_RD0, 64'd0, "rst_reg0");

    // Single write, read-after-write latency
    tick();
    wr(0, 4'd3, 64'hDEAD_BEEF);
    rd_idx = 8'h03;
`ifdef WB_BYPASS_EN
    expect_obs(K_RD0, 64'hDEAD_BEEF, "raw_same_cycle");
`else
    expect_obs(K_RD0, 64'd0, "raw_same_cycle");
`endif
    tick();
    idle();
    expect_obs(K_RD0, 64'hDEAD_BEEF, "raw_next_cycle");
    expect_obs(K_RET, 64'd1, "ret_after_1");

    // Two-channel MUL/DIV style packet
    wr(0, 4'd0, 64'd5);
    wr(1, 4'd2, 64'd7);
    tick();
    idle();
    rd_idx = 8'h20;
    expect_obs(K_RD0, 64'd5, "muldiv_reg0");
    expect_obs(K_RD1, 64'd7, "muldiv_reg2");
    expect_obs(K_RET, 64'd2, "ret_after_2");

    // Same-index conflict: highest channel wins
    wr(0, 4'd4, 64'd1);
    wr(1, 4'd4, 64'd2);
    tick();
    idle();
    rd_idx = 8'h34;
    expect_obs(K_RD0, 64'd2, "conflict_reg4");
    expect_obs(K_RD1, 64'hDEAD_BEEF, "reg3_kept");
    expect_obs(K_RET, 64'd3, "ret_after_3");

    // Reservation and write on the same register: set wins
    wr(0, 4'd4, 64'd8);
    rsv_valid = 1'b1;
    rsv_mask  = 16'h0010;
    tick();
    idle();
    rd_idx = 8'h04;
    expect_obs(K_BUSY, 64'h0010, "set_wins_busy");
    expect_obs(K_RD0, 64'd8, "set_wins_reg4");
    wr(0, 4'd4, 64'd9);
    tick();
    idle();
    expect_obs(K_BUSY, 64'h0000, "clear_busy4");
    expect_obs(K_RD0, 64'd9, "reg4_rewrite");
    expect_obs(K_RET, 64'd5, "ret_after_5");

    // Reset in the same cycle as a write discards the write
    reset = 1'b1;
    wr(0, 4'd5, 64'd9);
    rsv_valid = 1'b1;
    rsv_mask  = 16'h0020;
    tick();
    reset = 1'b0;
    idle();
    rd_idx = 8'h35;
    expect_obs(K_RD0, 64'd0, "rst_write_reg5");
    expect_obs(K_RD1, 64'd0, "rst_clears_reg3");
    expect_reset_state("rst2");

    // Write idx6 = 3 while reading idx6
    wr(0, 4'd6, 64'd3);
    rd_idx = 8'h06;
`ifdef WB_BYPASS_EN
    expect_obs(K_RD0, 64'd3, "bypass_reg6");
`else
    expect_obs(K_RD0, 64'd0, "nobypass_reg6");
`endif
    tick();
    idle();
    expect_obs(K_RD0, 64'd3, "reg6_stored");
    expect_obs(K_RET, 64'd1, "ret_after_rst");

    // Sim-end with an empty scoreboard halts directly
    in_valid   = 1'b1;
    in_sim_end = 1'b1;
    tick();
    idle();
    expect_obs(K_HALT,  64'd1, "halt_direct");
    expect_obs(K_READY, 64'd0, "halt_not_ready");
    expect_obs(K_RET,   64'd2, "ret_at_halt");
    wr(0, 4'd6, 64'd77);
    tick();
    idle();
    expect_obs(K_RD0,  64'd3, "halted_ignores_write");
    expect_obs(K_RET,  64'd2, "halted_ignores_count");
    expect_obs(K_HALT, 64'd1, "halt_sticky");

    // Sim-end with busy[1] set goes through PENDING_HALT
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    rsv_valid = 1'b1;
    rsv_mask  = 16'h0002;
    tick();
    idle();
    expect_obs(K_BUSY, 64'h0002, "rsv_busy1");
    in_valid   = 1'b1;
    in_sim_end = 1'b1;
    tick();
    idle();
    expect_obs(K_HALT,  64'd0, "pending_not_halted");
    expect_obs(K_READY, 64'd1, "pending_ready");
    expect_obs(K_RET,   64'd1, "pending_ret");
    wr(0, 4'd1, 64'd11);
    tick();
    idle();
    rd_idx = 8'h01;
    expect_obs(K_BUSY,  64'h0000, "pending_busy_drained");
    expect_obs(K_HALT,  64'd0, "pending_still_running");
    expect_obs(K_RD0,   64'd11, "pending_write_reg1");
    expect_obs(K_RET,   64'd2, "pending_accepts");
    tick();
    expect_obs(K_HALT,  64'd1, "pending_to_halted");
    expect_obs(K_READY, 64'd0, "pending_halt_not_ready");

    tick();
    tick();
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
